tone_sequencer: RTL
===================

TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter NOTE_CYC, default 12500000, clock cycles each note sounds (SE high); legal range >= 1.
REQ-002 Parameter GAP_CYC, default 2500000, silent clock cycles after each note (SE low); legal range >= 1.
REQ-003 Parameter DEPTH, default 16, sequence memory entries (fixed power of 2, 4-bit address).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 wr_en  input  1  write strobe for sequence memory.
REQ-007 wr_addr  input  4  memory write address.
REQ-008 wr_note  input  3  note code written (0..7, same coding as speaker "thing").
REQ-009 len  input  5  notes to play, 0..16, sampled only on accepted start.
REQ-010 start  input  1  request playback of mem[0..len-1].
REQ-011 abort  input  1  terminate playback or key tone immediately.
REQ-012 key_req  input  1  level request for a live feedback tone (player button held).
REQ-013 key_note  input  3  note for live feedback tone.
REQ-014 thing  output  3  note code to speaker.
REQ-015 SE  output  1  speaker enable to speaker.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse on normal playback completion.
REQ-018 idx  output  4  index of note currently being played/gapped.

Function
REQ-019 States SHALL be IDLE, NOTE, GAP, KEY; timer width sufficient for max(NOTE_CYC, GAP_CYC).
REQ-020 In IDLE, wr_en SHALL write wr_note to mem[wr_addr] at the clock edge; wr_en in any other state SHALL be ignored.
REQ-021 IDLE with start=1 and len>=1 SHALL go to NOTE next cycle with idx=0, latched length = min(len,16).
REQ-022 IDLE with start=1 and len=0 SHALL stay IDLE and pulse done the next cycle; no tone.
REQ-023 start has priority over key_req when both high in IDLE.
REQ-024 In NOTE, thing=mem[idx], SE=1 for exactly NOTE_CYC cycles, then GAP.
REQ-025 In GAP, SE=0, thing holds mem[idx], for exactly GAP_CYC cycles; then if idx = length-1, go IDLE and pulse done in the first IDLE cycle; else idx+1 and NOTE.
REQ-026 start and key_req SHALL be ignored while in NOTE or GAP (playback owns the speaker).
REQ-027 IDLE with key_req=1 (and no start) SHALL go KEY; in KEY thing=key_note (tracked each cycle), SE=1; key_req=0 returns to IDLE next cycle; no done pulse.
REQ-028 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with SE=0, no done pulse; abort in IDLE has no effect and blocks start that cycle.
REQ-029 In IDLE, SE=0, thing=0, idx holds last value.
REQ-030 Outputs thing, SE, busy, done, idx SHALL be registered (no combinational path from inputs).
REQ-031 Memory contents SHALL be preserved across playbacks and aborts.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, SE=0, thing=0, busy=0, done=0, idx=0, timer=0, regardless of clock.
REQ-033 Memory contents are not reset; unwritten entries are undefined until written.
REQ-034 Reset mid-playback SHALL produce no done pulse; first start after release plays from idx=0.

Verification (NOTE_CYC=4, GAP_CYC=2)
REQ-035 Write mem[0..2]=5,1,7; start, len=3 -> SE pattern 1111 00 repeated 3 times, thing 5,1,7, done one pulse 18 cycles after first NOTE cycle, busy low with done.
REQ-036 start with len=0 -> no SE, done pulse next cycle, busy stays 0.
REQ-037 Playback len=2, abort during second NOTE -> SE=0 and busy=0 next cycle, no done; new start len=1 plays mem[0].
REQ-038 key_req held 10 cycles, key_note 3 then 6 -> SE=1 for 10 cycles, thing follows key_note; key_req during playback -> no effect on thing/SE.
REQ-039 rst_n low mid-GAP of len=4 playback -> outputs zero asynchronously, no done; wr_en during playback leaves memory unchanged (verified by replay).
REQ-040 len=20 -> plays 16 notes then done.

Source files
------------

// File: rtl/tone_sequencer.sv
// Tone sequencer: plays a stored list of note codes with timed note/gap phases,
// and sounds a live feedback tone while a player key is held.
module tone_sequencer #(
    parameter int unsigned NOTE_CYC = 12500000,
    parameter int unsigned GAP_CYC  = 2500000,
    parameter int unsigned DEPTH    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [2:0] wr_note,
    input  logic [4:0] len,
    input  logic       start,
    input  logic       abort,
    input  logic       key_req,
    input  logic [2:0] key_note,
    output logic [2:0] thing,
    output logic       SE,
    output logic       busy,
    output logic       done,
    output logic [3:0] idx
);

    localparam int unsigned MAX_CYC = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {IDLE, NOTE, GAP, KEY} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      idx_q, idx_d;
    logic [4:0]      len_q, len_d;
    logic [2:0]      thing_q, thing_d;
    logic            se_q, se_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2:0]      mem [DEPTH];

    // Sequence memory: not reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && wr_en) begin
            mem[wr_addr] <= wr_note;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            thing_q <= '0;
            se_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            thing_q <= thing_d;
            se_q    <= se_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        len_d   = len_q;
        thing_d = thing_q;
        se_d    = se_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                thing_d = '0;
                se_d    = 1'b0;
                if (start && !abort) begin
                    if (len == 5'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = NOTE;
                        idx_d   = 4'd0;
                        len_d   = (len > 5'(DEPTH)) ? 5'(DEPTH) : len;
                        timer_d = '0;
                        thing_d = mem[4'd0];
                        se_d    = 1'b1;
                    end
                end else if (key_req) begin
                    state_d = KEY;
                    thing_d = key_note;
                    se_d    = 1'b1;
                end
            end
            NOTE: begin
                if (timer_q == TW'(NOTE_CYC - 1)) begin
                    state_d = GAP;
                    timer_d = '0;
                    se_d    = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                if (timer_q == TW'(GAP_CYC - 1)) begin
                    timer_d = '0;
                    if ({1'b0, idx_q} == len_q - 5'd1) begin
                        state_d = IDLE;
                        thing_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = NOTE;
                        idx_d   = idx_q + 4'd1;
                        thing_d = mem[idx_q + 4'd1];
                        se_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            KEY: begin
                thing_d = key_note;
                se_d    = 1'b1;
                if (!key_req) begin
                    state_d = IDLE;
                    thing_d = '0;
                    se_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything outside idle and suppresses done.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            timer_d = '0;
            thing_d = '0;
            se_d    = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign thing = thing_q;
    assign SE    = se_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign idx   = idx_q;

endmodule
